// File: rtl/out_queue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// out_queue_scheduler_pkg
// Shared definitions for the per-output-port dequeue scheduler:
//   - default sizing (queue count, WRR weight width, queue id width)
//   - FSM state encoding used by the top module
// ---------------------------------------------------------------------------
package out_queue_scheduler_pkg;

    localparam int NUM_OF_QUEUES  = 8;
    localparam int WEIGHT_WIDTH   = 4;
    localparam int QUEUE_ID_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } state_t;

endpackage

// File: rtl/out_queue_scheduler_rr_picker.sv
// ---------------------------------------------------------------------------
// out_queue_scheduler_rr_picker  (rr_picker)
// Combinational round-robin search: returns the first set bit of req found
// when walking from ptr+1 upward, wrapping to 0 after the last queue.
// Ports:
//   req    in   request / eligibility vector, one bit per queue
//   ptr    in   index of the last granted queue
//   found  out  at least one request bit is set
//   idx    out  winning queue index (0 when found is low)
// ---------------------------------------------------------------------------
module out_queue_scheduler_rr_picker
    import out_queue_scheduler_pkg::*;
#(
    parameter int num_of_queues  = NUM_OF_QUEUES,
    parameter int queue_id_width = QUEUE_ID_WIDTH
) (
    input  logic [num_of_queues-1:0]  req,
    input  logic [queue_id_width-1:0] ptr,
    output logic                      found,
    output logic [queue_id_width-1:0] idx
);

    int                        cand_int;
    logic [queue_id_width-1:0] cand;

    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand_int = 0;
        cand     = '0;
        // Offset 1 is the queue right after the last grant; offset
        // num_of_queues comes back around to the last granted queue itself.
        for (int k = 1; k <= num_of_queues; k++) begin
            cand_int = (int'(ptr) + k) % num_of_queues;
            cand     = queue_id_width'(cand_int);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/out_queue_scheduler.sv
// ---------------------------------------------------------------------------
// out_queue_scheduler
// Dequeue scheduler for one output port. Picks one of num_of_queues priority
// queues (strict priority or weighted round robin) and holds the grant until
// the end-of-packet word has been popped.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   sp0_wrr1    in   0 = strict priority, 1 = WRR (used only in IDLE)
//   q_nonempty  in   bit i = queue i holds a complete packet
//   weights     in   WRR weight of queue i at [(i+1)*W-1 : i*W]
//   rd_ready    in   downstream accepts one word this cycle
//   eop_in      in   popped word is end of packet (qualified by rd_en)
//   grant_vld   out  a queue is granted (GRANT and XFER)
//   grant_q     out  granted queue index
//   rd_en       out  pop one word from grant_q
//   busy        out  packet in progress (GRANT or XFER)
// ---------------------------------------------------------------------------
module out_queue_scheduler
    import out_queue_scheduler_pkg::*;
#(
    parameter int num_of_queues  = NUM_OF_QUEUES,
    parameter int weight_width   = WEIGHT_WIDTH,
    parameter int queue_id_width = QUEUE_ID_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sp0_wrr1,
    input  logic [num_of_queues-1:0]              q_nonempty,
    input  logic [num_of_queues*weight_width-1:0] weights,
    input  logic                                  rd_ready,
    input  logic                                  eop_in,
    output logic                                  grant_vld,
    output logic [queue_id_width-1:0]             grant_q,
    output logic                                  rd_en,
    output logic                                  busy
);

    state_t                                      state_reg;
    logic [queue_id_width-1:0]                   grant_q_reg;
    logic                                        grant_vld_reg;
    logic                                        busy_reg;
    logic [queue_id_width-1:0]                   ptr_reg;
    logic [num_of_queues-1:0][weight_width-1:0]  credit_reg;
    // Mode used by the most recent selection; a 0->1 change marks WRR entry.
    logic                                        wrr_mode_reg;

    logic [num_of_queues-1:0][weight_width-1:0]  weight_eff;
    logic [num_of_queues-1:0][weight_width-1:0]  credit_use;
    logic [num_of_queues-1:0][weight_width-1:0]  credit_next;
    logic [num_of_queues-1:0]                    credit_nz;
    logic [num_of_queues-1:0]                    eligible;
    logic                                        wrr_enter;
    logic                                        wrr_reload;
    logic [queue_id_width-1:0]                   ptr_eff;
    logic                                        rr_found;
    logic [queue_id_width-1:0]                   rr_idx;
    logic [queue_id_width-1:0]                   sp_idx;
    logic                                        sel_valid;

    // ------------------------------------------------------------------
    // WRR credit bookkeeping
    // ------------------------------------------------------------------
    assign wrr_enter  = !wrr_mode_reg;
    // Reload when entering WRR, or when every requester has run out of credit.
    assign wrr_reload = wrr_enter || ((q_nonempty & credit_nz) == '0);
    assign ptr_eff    = wrr_enter ? queue_id_width'(num_of_queues - 1) : ptr_reg;

    generate
        for (genvar gi = 0; gi < num_of_queues; gi++) begin : g_credit
            // A zero weight still earns one packet per round so nothing starves.
            assign weight_eff[gi] = (weights[gi*weight_width +: weight_width] == '0)
                                    ? weight_width'(1)
                                    : weights[gi*weight_width +: weight_width];
            assign credit_nz[gi]  = (credit_reg[gi] != '0);
            assign credit_use[gi] = wrr_reload ? weight_eff[gi] : credit_reg[gi];
            assign eligible[gi]   = q_nonempty[gi] && (credit_use[gi] != '0);
            assign credit_next[gi] = ((rr_idx == queue_id_width'(gi)) && (credit_use[gi] != '0))
                                     ? credit_use[gi] - weight_width'(1)
                                     : credit_use[gi];
        end
    endgenerate

    out_queue_scheduler_rr_picker #(
        .num_of_queues  (num_of_queues),
        .queue_id_width (queue_id_width)
    ) u_rr_picker (
        .req   (eligible),
        .ptr   (ptr_eff),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // ------------------------------------------------------------------
    // Strict priority: highest set index wins (later iterations override).
    // ------------------------------------------------------------------
    always_comb begin
        sp_idx = '0;
        for (int i = 0; i < num_of_queues; i++) begin
            if (q_nonempty[i]) begin
                sp_idx = queue_id_width'(i);
            end
        end
    end

    assign sel_valid = sp0_wrr1 ? rr_found : (|q_nonempty);

    // ------------------------------------------------------------------
    // FSM with registered grant outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            grant_q_reg   <= '0;
            grant_vld_reg <= 1'b0;
            busy_reg      <= 1'b0;
            ptr_reg       <= queue_id_width'(num_of_queues - 1);
            credit_reg    <= '0;
            wrr_mode_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel_valid) begin
                        state_reg     <= GRANT;
                        grant_vld_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        wrr_mode_reg  <= sp0_wrr1;
                        if (sp0_wrr1) begin
                            grant_q_reg <= rr_idx;
                            ptr_reg     <= rr_idx;
                            credit_reg  <= credit_next;
                        end else begin
                            grant_q_reg <= sp_idx;
                        end
                    end
                end
                GRANT: begin
                    state_reg <= XFER;
                end
                XFER: begin
                    if (rd_ready && eop_in) begin
                        state_reg     <= IDLE;
                        grant_vld_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    grant_vld_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign grant_vld = grant_vld_reg;
    assign grant_q   = grant_q_reg;
    assign busy      = busy_reg;
    // Combinational so the pop lines up with downstream acceptance this cycle.
    assign rd_en     = (state_reg == XFER) && rd_ready;

endmodule

// File: tb/tb_out_queue_scheduler.sv
module tb_out_queue_scheduler;

    localparam int NQ = 8;
    localparam int WW = 4;
    localparam int QW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sp0_wrr1 = 1'b0;
    logic [NQ-1:0]     q_nonempty = '0;
    logic [NQ*WW-1:0]  weights = '0;
    logic              rd_ready = 1'b0;
    logic              eop_in = 1'b0;
    logic              grant_vld;
    logic [QW-1:0]     grant_q;
    logic              rd_en;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: packet credits per queue, last-granted pointer,
    // and whether the previous selection was made in WRR mode.
    int cr[NQ];
    int ptr;
    bit wrr_prev;

    always #5 clk = ~clk;

    out_queue_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .sp0_wrr1   (sp0_wrr1),
        .q_nonempty (q_nonempty),
        .weights    (weights),
        .rd_ready   (rd_ready),
        .eop_in     (eop_in),
        .grant_vld  (grant_vld),
        .grant_q    (grant_q),
        .rd_en      (rd_en),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NQ; i++) cr[i] = 0;
        ptr = NQ - 1;
        wrr_prev = 1'b0;
    endtask

    task automatic model_reload(input logic [NQ*WW-1:0] w);
        for (int i = 0; i < NQ; i++) begin
            cr[i] = int'(w[i*WW +: WW]);
            if (cr[i] == 0) cr[i] = 1;
        end
    endtask

    // Selection rules straight from the description of SP and WRR behaviour.
    task automatic model_pick(input logic [NQ-1:0] req, input bit sp, input logic [NQ*WW-1:0] w,
                              output int q);
        bit any;
        q = -1;
        if (!sp) begin
            for (int i = 0; i < NQ; i++) if (req[i]) q = i;
            wrr_prev = 1'b0;
        end else begin
            if (!wrr_prev) begin
                model_reload(w);
                ptr = NQ - 1;
            end
            any = 1'b0;
            for (int i = 0; i < NQ; i++) if (req[i] && cr[i] > 0) any = 1'b1;
            if (!any) model_reload(w);
            for (int k = 1; k <= NQ; k++) begin
                int c;
                c = (ptr + k) % NQ;
                if (q < 0 && req[c] && cr[c] > 0) q = c;
            end
            cr[q] = cr[q] - 1;
            ptr = q;
            wrr_prev = 1'b1;
        end
    endtask

    // Starts in IDLE at posedge+1. bp: 0 always ready, 1 ready low for XFER
    // cycles 1..3, 2 random. Ends at posedge+1 of the IDLE bubble.
    task automatic run_packet(input logic [NQ-1:0] req, input bit sp, input logic [NQ*WW-1:0] w,
                              input int words, input int bp, output logic [QW-1:0] got);
        int exp_q;
        int pops;
        int cyc;
        bit done;
        q_nonempty = req;
        sp0_wrr1   = sp;
        weights    = w;
        rd_ready   = 1'($urandom % 2);
        eop_in     = 1'($urandom % 2);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_grant_vld", grant_vld, 0);
        chk("idle_rd_en", rd_en, 0);
        model_pick(req, sp, w, exp_q);
        @(posedge clk); #1;
        // Input changes from here on must not affect this packet.
        q_nonempty = NQ'($urandom);
        sp0_wrr1   = 1'($urandom % 2);
        weights    = (NQ*WW)'($urandom);
        rd_ready   = 1'b1;
        eop_in     = 1'b1;
        #1;
        chk("grant_vld", grant_vld, 1);
        chk("grant_busy", busy, 1);
        chk("grant_rd_en", rd_en, 0);
        chk("grant_q", grant_q, exp_q);
        got  = grant_q;
        pops = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 64) begin
            @(posedge clk); #1;
            case (bp)
                0:       rd_ready = 1'b1;
                1:       rd_ready = !(cyc >= 1 && cyc <= 3);
                default: rd_ready = ($urandom % 3) != 0;
            endcase
            eop_in     = rd_ready ? (pops == words - 1) : 1'($urandom % 2);
            q_nonempty = NQ'($urandom);
            sp0_wrr1   = 1'($urandom % 2);
            #1;
            chk("xfer_rd_en", rd_en, rd_ready);
            chk("xfer_grant_q", grant_q, exp_q);
            chk("xfer_busy", busy, 1);
            if (rd_en === 1'b1) begin
                pops++;
                if (eop_in) done = 1'b1;
            end
            cyc++;
        end
        chk("packet_done", done, 1);
        chk("pop_count", pops, words);
        @(posedge clk); #1;
        rd_ready = 1'b0;
        eop_in   = 1'b0;
    endtask

    logic [NQ-1:0] req;
    logic [QW-1:0] got;
    int sp_exp[3]   = '{7, 2, 0};
    int wrr_exp[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 2, 2};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant_vld", grant_vld, 0);
        chk("rst_grant_q", grant_q, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Idle with no requests stays idle.
        q_nonempty = '0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_req_busy", busy, 0);
        end

        // Strict priority drains q7, q2, q0.
        req = 8'b1000_0101;
        for (int k = 0; k < 3; k++) begin
            run_packet(req, 1'b0, '0, 3, 0, got);
            chk("sp_basic_order", got, sp_exp[k]);
            req[got] = 1'b0;
        end

        // WRR with q0=2, q1=1, q2=3, others 1; second round checked by the model.
        for (int k = 0; k < 22; k++) begin
            run_packet(8'hFF, 1'b1, 32'h1111_1312, 1, 0, got);
            if (k < 11) chk("wrr_weights_order", got, wrr_exp[k]);
        end

        // Zero weight on the only requester still gets served every time.
        for (int k = 0; k < 5; k++) begin
            run_packet(8'h08, 1'b1, '0, 2, 0, got);
            chk("weight_zero", got, 3);
        end

        // Backpressure in the middle of a 4-word packet.
        run_packet(8'h10, 1'b0, '0, 4, 1, got);
        chk("backpressure_q", got, 4);

        // Mode switch: SP packet (inputs toggle mid-packet), then WRR from q0.
        run_packet(8'hFF, 1'b0, 32'h1111_1111, 3, 0, got);
        chk("mode_sp_q", got, 7);
        run_packet(8'hFF, 1'b1, 32'h1111_1111, 2, 0, got);
        chk("mode_wrr_first_q", got, 0);

        // Reset during the second word of a packet.
        q_nonempty = 8'h80;
        sp0_wrr1   = 1'b0;
        @(posedge clk); #1;
        rd_ready = 1'b1;
        eop_in   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_rd_en", rd_en, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_grant_vld", grant_vld, 0);
        chk("mid_rst_grant_q", grant_q, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        rd_ready = 1'b0;
        model_reset();
        run_packet(8'h20, 1'b0, '0, 1, 0, got);
        chk("post_rst_q5", got, 5);
        run_packet(8'hFF, 1'b1, 32'h1111_1111, 1, 0, got);
        chk("post_rst_wrr_q0", got, 0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 200; k++) begin
            if ($urandom % 8 == 0) begin
                q_nonempty = '0;
                @(posedge clk); #1;
                chk("rand_idle_busy", busy, 0);
            end
            run_packet(NQ'($urandom_range(1, 255)), ($urandom % 4) != 0, (NQ*WW)'($urandom),
                       int'($urandom_range(1, 4)), 2, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
